disp_scan_mux: RTL and testbench
================================

# disp_scan_mux

Time-multiplexed scanner for a common-anode multi-digit 7-segment display. Holds a packed hex value, cycles through its digits at a prescaled refresh rate, and presents one 4-bit nibble per slot to the downstream hex-to-segment decoder together with an active-low one-hot digit select. New values are double-buffered and take effect only at frame boundaries, so a scan never shows digits from two different values.

## Interface
- DIGITS, 4: number of display digits; legal range 2..8.
- PRESCALE, 50000: clocks per digit slot; must be at least 2.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- value_in  in  4*DIGITS  packed hex value; digit 0 is in bits [3:0].
- load  in  1  single-cycle strobe that captures value_in into the shadow register.
- nibble  out  4  hex digit for the current slot; feeds the segment decoder.
- digit_sel  out  DIGITS  active-low one-hot anode select; all ones means every digit is off.
- blank  out  1  high when the current slot is suppressed.
- frame_done  out  1  one-cycle pulse on the last tick of each frame.

## Operation
- Prescaler pcnt counts 0..PRESCALE-1 and then wraps to 0. tick = (pcnt == PRESCALE-1).
- Digit index idx advances by 1 on each tick and wraps from DIGITS-1 to 0.
- Frame boundary: tick && idx == DIGITS-1. frame_done is registered and is high for the cycle that follows the boundary edge.
- load=1 sets shadow <= value_in and pending <= 1. Repeated loads before a boundary overwrite the shadow, so the last one wins.
- At a boundary edge:
  - If pending is set, disp_q <= shadow and pending <= 0.
  - If load is high in the same cycle as the boundary, disp_q <= value_in directly, pending <= 0, and shadow <= value_in.
- nibble = disp_q[4*idx +: 4]. It is driven only from registers, with no combinational path from inputs.
- digit_sel = ~(1 << idx), or all ones when blank=1.
- blank = 0 unless the feature described under Configuration is compiled in.
- Reset, applied immediately even mid-frame:
  - pcnt=0, idx=0, disp_q=0, shadow=0, pending=0.
  - Outputs: nibble=0, digit_sel=~1 (digit 0 on), blank=0, frame_done=0.
- Width rules:
  - pcnt uses $clog2(PRESCALE) bits.
  - idx uses $clog2(DIGITS) bits.
  - Comparisons are unsigned, and wrap is explicit rather than relying on overflow, so non-power-of-two values work.

## Timing
- Each slot lasts exactly PRESCALE clocks; a frame lasts DIGITS*PRESCALE clocks.
- digit_sel, nibble and blank change together on the tick edge, with no intermediate cycle.
- Latency from load to display:
  - Minimum 0 cycles, when load coincides with the boundary.
  - Maximum DIGITS*PRESCALE cycles.
- After reset release, the first tick occurs PRESCALE cycles after the first rising edge.

## Configuration
- DISP_LZB_EN enables leading-zero blanking.
- When defined:
  - blank=1 for slot idx if idx != 0 and every nibble of disp_q from idx to DIGITS-1 is zero.
  - While blank=1, digit_sel is all ones.
  - Digit 0 is never blanked.
- When undefined: blank is tied to 0 and no blanking logic is synthesised.

## Structure
- The shared package disp_pkg holds:
  - NIBBLE_W = 4.
  - The active-low select constant SEL_OFF.
  - An idx_t typedef derived from DIGITS.
- Sub-module disp_prescaler (parameter PRESCALE; ports clk, rst_n, tick) holds pcnt and produces tick. Everything else stays in disp_scan_mux.

## Test plan
Default bench configuration: DIGITS=4, PRESCALE=4.
- Reset: hold rst_n=0 -> nibble=0, digit_sel=4'b1110, blank=0, frame_done=0. Release -> first tick occurs 4 clocks later.
- Load mid-frame: load with value_in=16'h1234 at idx=1 -> the current frame still shows 0. After the boundary, digit 0 shows nibble=4 with sel=1110; 4 clocks later, digit 1 shows nibble=3 with sel=1101. frame_done pulses every 16 clocks.
- Back-to-back loads: loads of 16'hAAAA and then 16'hBEEF before the boundary -> the next frame shows F, E, E, B.
- Load on the boundary: load 16'h00C5 in the boundary cycle -> digit 0 shows 5 immediately after the edge, and pending stays 0.
- Leading-zero blanking: value 16'h0050 with DISP_LZB_EN -> slots 3 and 2 have blank=1 and sel=1111; slot 1 shows 5; slot 0 shows 0 unblanked. Without the macro, all four slots are lit. Value 0 -> only digit 0 is lit.
- Reset mid-operation: drop rst_n at idx=2 with pending=1 -> outputs return to reset values within the same cycle, and after release the pending value is discarded.

Source files
------------

// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and types for the 7-segment scan multiplexer.
// Holds the nibble width, the all-off anode select pattern and the digit
// index type for the default digit count.
package disp_pkg;

    localparam int NIBBLE_W    = 4;
    localparam int DIGITS_MAX  = 8;
    localparam int DISP_DIGITS = 4;

    // Anodes are active-low, so all ones turns every digit off; slice to DIGITS.
    localparam logic [DIGITS_MAX-1:0] SEL_OFF = '1;

    typedef logic [$clog2(DISP_DIGITS)-1:0] idx_t;

endpackage

// File: rtl/disp_prescaler.sv
// disp_prescaler: free-running slot timer. Counts 0..PRESCALE-1 and asserts
// tick on the final count so each digit slot lasts exactly PRESCALE clocks.
module disp_prescaler #(
    parameter int PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int                PCNT_W   = $clog2(PRESCALE);
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESCALE - 1);

    logic [PCNT_W-1:0] pcnt_q;
    logic [PCNT_W-1:0] pcnt_d;

    // Explicit wrap so non-power-of-two prescale values keep exact slot length.
    always_comb begin
        tick   = (pcnt_q == PCNT_MAX);
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    end

    // Prescale counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/disp_scan_mux.sv
// disp_scan_mux: time-multiplexed scanner for a common-anode multi-digit
// 7-segment display. A shadow register captures new values on load; they
// reach the displayed register only at frame boundaries so a scan never mixes
// two values. Optional leading-zero blanking is compiled in with DISP_LZB_EN.
import disp_pkg::*;

module disp_scan_mux #(
    parameter int DIGITS   = DISP_DIGITS,
    parameter int PRESCALE = 50000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NIBBLE_W*DIGITS-1:0]   value_in,
    input  logic                         load,
    output logic [NIBBLE_W-1:0]          nibble,
    output logic [DIGITS-1:0]            digit_sel,
    output logic                         blank,
    output logic                         frame_done
);

    localparam int                 IDX_W       = $clog2(DIGITS);
    localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0]  SEL_ALL_OFF = SEL_OFF[DIGITS-1:0];

    logic                        tick;
    logic                        boundary;

    logic [IDX_W-1:0]            idx_q,        idx_d;
    logic [NIBBLE_W*DIGITS-1:0]  disp_q,       disp_d;
    logic [NIBBLE_W*DIGITS-1:0]  shadow_q,     shadow_d;
    logic                        pending_q,    pending_d;
    logic                        frame_done_q, frame_done_d;

    logic [DIGITS-1:0]           sel_on;
    logic [NIBBLE_W-1:0]         nib_cur;

    disp_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Slot advance, double-buffer handoff and frame pulse; a load coinciding
    // with the boundary bypasses the shadow and is shown immediately.
    always_comb begin
        boundary     = tick && (idx_q == IDX_LAST);
        idx_d        = idx_q;
        disp_d       = disp_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        frame_done_d = boundary;

        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        if (load) begin
            shadow_d  = value_in;
            pending_d = 1'b1;
        end

        if (boundary) begin
            pending_d = 1'b0;
            if (load) begin
                disp_d = value_in;
            end else if (pending_q) begin
                disp_d = shadow_q;
            end
        end
    end

    // Scan state registers; reset takes effect immediately, even mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            disp_q       <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Select the current digit's nibble and its anode, purely from registers.
    always_comb begin
        sel_on  = SEL_ALL_OFF;
        nib_cur = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == idx_q) begin
                sel_on[i] = 1'b0;
                nib_cur   = disp_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

`ifdef DISP_LZB_EN
    logic upper_zero;

    // Blank a slot when it and every more-significant digit are zero; digit 0 stays lit.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ((IDX_W'(i) >= idx_q) && (disp_q[i*NIBBLE_W +: NIBBLE_W] != '0)) begin
                upper_zero = 1'b0;
            end
        end
        blank = (idx_q != '0) && upper_zero;
    end
`else
    assign blank = 1'b0;
`endif

    assign nibble     = nib_cur;
    assign digit_sel  = blank ? SEL_ALL_OFF : sel_on;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// tb_disp_scan_mux: bench for disp_scan_mux with DIGITS=4, PRESCALE=4.
// Directed vector table, hand-written corner sequences and a randomized
// phase, all compared against a cycle-count based reference model.
module tb_disp_scan_mux;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;
    localparam int FRAME    = DIGITS * PRESCALE;
`ifdef DISP_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  nibble;
    logic [3:0]  digit_sel;
    logic        blank;
    logic        frame_done;

    disp_scan_mux #(
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .load       (load),
        .nibble     (nibble),
        .digit_sel  (digit_sel),
        .blank      (blank),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: clocks since reset release, shown value, shadow, pending.
    int unsigned mc;
    logic [15:0] m_shown;
    logic [15:0] m_shadow;
    bit          m_pend;
    bit          m_fd;

    typedef struct {
        logic        ld;
        logic [15:0] val;
        logic [3:0]  nib;
        logic [3:0]  sel;
        logic        zl;   // slot would be blanked with leading-zero blanking
        logic        fd;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        mc       = 0;
        m_shown  = '0;
        m_shadow = '0;
        m_pend   = 1'b0;
        m_fd     = 1'b0;
    endtask

    function automatic int m_idx();
        return (mc / PRESCALE) % DIGITS;
    endfunction

    function automatic bit m_blank();
        int id;
        id = m_idx();
        return LZB && (id != 0) && ((m_shown >> (4 * id)) == 16'h0);
    endfunction

    function automatic logic [3:0] m_sel();
        if (m_blank()) return 4'hF;
        return ~(4'b0001 << m_idx());
    endfunction

    function automatic logic [3:0] m_nib();
        return 4'((m_shown >> (4 * m_idx())) & 16'h000F);
    endfunction

    task automatic compare_model();
        chk($sformatf("model_nibble c=%0d", mc),     32'(nibble),     32'(m_nib()));
        chk($sformatf("model_sel c=%0d", mc),        32'(digit_sel),  32'(m_sel()));
        chk($sformatf("model_blank c=%0d", mc),      32'(blank),      32'(m_blank()));
        chk($sformatf("model_frame_done c=%0d", mc), 32'(frame_done), 32'(m_fd));
    endtask

    // One clock: drive inputs, advance the model at the edge, check at negedge.
    task automatic do_cycle(input logic ld, input logic [15:0] val);
        bit          bnd;
        logic [15:0] old_sh;
        load     = ld;
        value_in = val;
        @(posedge clk);
        bnd    = (mc % FRAME) == (FRAME - 1);
        old_sh = m_shadow;
        if (ld) m_shadow = val;
        if (bnd) begin
            if (ld)          m_shown = val;
            else if (m_pend) m_shown = old_sh;
            m_pend = 1'b0;
        end else if (ld) begin
            m_pend = 1'b1;
        end
        m_fd = bnd;
        mc++;
        @(negedge clk);
        load = 1'b0;
        compare_model();
    endtask

    task automatic run_to(input int unsigned target);
        while (mc < target) do_cycle(1'b0, 16'h0000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] masks[5];
        logic [3:0]  exp_sel;

        tbl = '{
            '{1'b0, 16'h0000, 4'h0, 4'hE, 1'b0, 1'b0},  // c=1
            '{1'b0, 16'h0000, 4'h0, 4'hE, 1'b0, 1'b0},  // c=2
            '{1'b0, 16'h0000, 4'h0, 4'hE, 1'b0, 1'b0},  // c=3
            '{1'b0, 16'h0000, 4'h0, 4'hD, 1'b1, 1'b0},  // c=4 first tick
            '{1'b0, 16'h0000, 4'h0, 4'hD, 1'b1, 1'b0},  // c=5
            '{1'b1, 16'h1234, 4'h0, 4'hD, 1'b1, 1'b0},  // c=6 load at idx 1
            '{1'b0, 16'h0000, 4'h0, 4'hD, 1'b1, 1'b0},
            '{1'b0, 16'h0000, 4'h0, 4'hB, 1'b1, 1'b0},  // c=8
            '{1'b0, 16'h0000, 4'h0, 4'hB, 1'b1, 1'b0},
            '{1'b0, 16'h0000, 4'h0, 4'hB, 1'b1, 1'b0},
            '{1'b0, 16'h0000, 4'h0, 4'hB, 1'b1, 1'b0},
            '{1'b0, 16'h0000, 4'h0, 4'h7, 1'b1, 1'b0},  // c=12
            '{1'b0, 16'h0000, 4'h0, 4'h7, 1'b1, 1'b0},
            '{1'b0, 16'h0000, 4'h0, 4'h7, 1'b1, 1'b0},
            '{1'b0, 16'h0000, 4'h0, 4'h7, 1'b1, 1'b0},
            '{1'b0, 16'h0000, 4'h4, 4'hE, 1'b0, 1'b1},  // c=16 boundary
            '{1'b0, 16'h0000, 4'h4, 4'hE, 1'b0, 1'b0},
            '{1'b0, 16'h0000, 4'h4, 4'hE, 1'b0, 1'b0},
            '{1'b0, 16'h0000, 4'h4, 4'hE, 1'b0, 1'b0},
            '{1'b0, 16'h0000, 4'h3, 4'hD, 1'b0, 1'b0}   // c=20
        };

        // Reset state
        rst_n    = 1'b0;
        load     = 1'b0;
        value_in = '0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_nibble",     32'(nibble),     32'h0);
        chk("rst_sel",        32'(digit_sel),  32'hE);
        chk("rst_blank",      32'(blank),      32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        rst_n = 1'b1;

        // Table: load mid-frame, first tick timing, boundary handoff
        for (int i = 0; i < 20; i++) begin
            do_cycle(tbl[i].ld, tbl[i].val);
            exp_sel = (LZB && tbl[i].zl) ? 4'hF : tbl[i].sel;
            chk($sformatf("tbl_nibble[%0d]", i), 32'(nibble),     32'(tbl[i].nib));
            chk($sformatf("tbl_sel[%0d]", i),    32'(digit_sel),  32'(exp_sel));
            chk($sformatf("tbl_blank[%0d]", i),  32'(blank),      32'(LZB && tbl[i].zl));
            chk($sformatf("tbl_fd[%0d]", i),     32'(frame_done), 32'(tbl[i].fd));
        end

        // Back-to-back loads: last one wins
        do_cycle(1'b1, 16'hAAAA);
        do_cycle(1'b1, 16'hBEEF);
        run_to(32);
        chk("b2b_slot0", 32'(nibble), 32'hF);
        chk("b2b_fd",    32'(frame_done), 32'h1);
        run_to(36);
        chk("b2b_slot1", 32'(nibble), 32'hE);
        run_to(40);
        chk("b2b_slot2", 32'(nibble), 32'hE);
        run_to(44);
        chk("b2b_slot3", 32'(nibble), 32'hB);
        chk("b2b_sel3",  32'(digit_sel), 32'h7);

        // Load in the boundary cycle shows at once and leaves nothing pending
        run_to(47);
        do_cycle(1'b1, 16'h00C5);
        chk("bnd_nibble",  32'(nibble),        32'h5);
        chk("bnd_sel",     32'(digit_sel),     32'hE);
        chk("bnd_pending", 32'(dut.pending_q), 32'h0);

        // Leading-zero pattern 0050
        do_cycle(1'b1, 16'h0050);
        run_to(64);
        chk("lzb_s0_nib",   32'(nibble),    32'h0);
        chk("lzb_s0_blank", 32'(blank),     32'h0);
        chk("lzb_s0_sel",   32'(digit_sel), 32'hE);
        run_to(68);
        chk("lzb_s1_nib",   32'(nibble),    32'h5);
        chk("lzb_s1_sel",   32'(digit_sel), 32'hD);
        run_to(72);
        chk("lzb_s2_blank", 32'(blank),     32'(LZB));
        chk("lzb_s2_sel",   32'(digit_sel), LZB ? 32'hF : 32'hB);
        run_to(76);
        chk("lzb_s3_blank", 32'(blank),     32'(LZB));
        chk("lzb_s3_sel",   32'(digit_sel), LZB ? 32'hF : 32'h7);

        // Value zero: only digit 0 lit under blanking
        do_cycle(1'b1, 16'h0000);
        run_to(80);
        chk("zero_s0_sel", 32'(digit_sel), 32'hE);
        run_to(84);
        chk("zero_s1_sel", 32'(digit_sel), LZB ? 32'hF : 32'hD);

        // Reset mid-operation at idx 2 with a pending value
        do_cycle(1'b1, 16'h9876);
        run_to(88);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_nibble",  32'(nibble),        32'h0);
        chk("mid_rst_sel",     32'(digit_sel),     32'hE);
        chk("mid_rst_blank",   32'(blank),         32'h0);
        chk("mid_rst_fd",      32'(frame_done),    32'h0);
        chk("mid_rst_pending", 32'(dut.pending_q), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        run_to(16);
        chk("post_rst_discard", 32'(nibble), 32'h0);
        chk("post_rst_fd",      32'(frame_done), 32'h1);

        // Randomized phase against the model
        masks = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
        for (int n = 0; n < 400; n++) begin
            logic        ld;
            logic [15:0] v;
            ld = ($urandom_range(0, 4) == 0);
            v  = 16'($urandom()) & masks[$urandom_range(0, 4)];
            do_cycle(ld, v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
